alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- ALU reservation station; the consumer end of the ID pipeline-register interface.
- Accepts one decoded, renamed instruction per cycle from the id_* outputs.
- Holds each instruction until both operands are known, capturing results from the common data bus (CDB).
- Issues one ready instruction per cycle to the ALU; drives rs_full back as the ID stall.

Parameters:
- RS_DEPTH, 4, number of station entries (power of 2, ≥2)
- ROB_DEPTH, 8, ROB entries; tag width = $clog2(ROB_DEPTH)
- WORD_WIDTH, 32, operand/data width
- PC_WIDTH, 32, PC width
- ALU_OP_WIDTH, 4, ALU opcode width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_en  in  1  global enable; low freezes all state
- rs_flush  in  1  kill all entries and the issue register
- id_en  in  1  valid instruction presented by ID register
- id_pc  in  PC_WIDTH  instruction PC
- id_alu_op  in  ALU_OP_WIDTH  ALU operation
- id_use_imm  in  1  src2 = id_imm instead of rs2
- id_imm  in  WORD_WIDTH  immediate
- id_alloc_rob  in  tag  destination ROB index
- id_rs1_rat_valid / id_rs2_rat_valid  in  1  operand is renamed (pending in ROB)
- id_rs1_Paddr / id_rs2_Paddr  in  tag  producer ROB index
- id_rs1_value_fromGPR / id_rs2_value_fromGPR  in  WORD_WIDTH  architectural value
- rob_rs1_ready / rob_rs2_ready  in  1  producer already completed (ROB lookup on Paddr)
- rob_rs1_value / rob_rs2_value  in  WORD_WIDTH  completed value from ROB
- cdb_valid  in  1  result broadcast
- cdb_rob  in  tag  broadcasting ROB index
- cdb_value  in  WORD_WIDTH  broadcast result
- rs_full  out  1  no free entry; drives id_stall
- issue_valid  out  1  issue register holds an instruction
- alu_ready  in  1  ALU accepts the issue register this cycle
- issue_alu_op  out  ALU_OP_WIDTH
- issue_src1 / issue_src2  out  WORD_WIDTH  resolved operands
- issue_rob  out  tag  destination ROB index
- issue_pc  out  PC_WIDTH

Behaviour:
- Reset: all entry valid bits 0; issue_valid 0; all issue_* outputs 0. rs_full is 0 after reset.
- Priority: rst > !cpu_en (hold everything) > rs_flush (clear entry valid bits and issue_valid next edge; no allocation or issue that cycle) > normal operation.
- rs_full = all entry valid bits set. Computed from registered state only; no combinational path from alu_ready or CDB.
- Allocate:
  - Condition: id_en && !rs_full.
  - Target entry: lowest-index free entry.
  - Operand resolution, per operand, in priority order:
    1. not rat_valid → GPR value, ready
    2. cdb_valid && cdb_rob==Paddr → cdb_value, ready
    3. rob_ready → rob value, ready
    4. otherwise store the tag, not ready
  - id_use_imm → src2 = id_imm, ready.
  - An entry freed in the same cycle does not lift rs_full for that cycle.
- Wakeup: each valid, not-ready operand whose tag equals cdb_rob while cdb_valid captures cdb_value and becomes ready at the edge.
- Select: lowest-index entry with both operands ready.
- Issue register load:
  - Loads when (!issue_valid || alu_ready) and a selected entry exists.
  - The selected entry is freed on the same edge.
  - If there is no selected entry and alu_ready, issue_valid drops to 0.
  - issue_valid && !alu_ready → issue_* held stable.
- Latency: an instruction with ready operands is allocated at edge N, loaded into the issue register at N+1, and visible on issue_valid after N+1.
- A newly allocated entry is not selectable in its allocation cycle.
- Throughput: one allocate and one issue per cycle.
- Tags are compared at full tag width; no wrap handling is needed because ROB indices are unique while in flight.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- Defined: an entry whose only non-ready operand(s) match the current CDB broadcast is selectable in that cycle. cdb_value is forwarded straight into the issue register, saving one cycle.
- Undefined: the entry becomes selectable the cycle after capture.

Decomposition:
- Shared defines file: RS_DEPTH, tag width derived from ROB_DEPTH, ALU_OP_WIDTH, and entry field offsets.
- Sub-module rs_pick: parameterised lowest-index priority encoder. Used twice, once for the free-entry search and once for the ready-entry search. Outputs index plus found flag.

Test Plan:
- Ready operands: after reset, inject add with rs1 = GPR 5, rs2 = GPR 7, rob 3, alu_ready=1 → issue_valid two edges later with src1=5, src2=7, issue_rob=3.
- CDB wakeup: rs1 pending on tag 2. Broadcast cdb_rob=2, cdb_value=0x1234 three cycles later → issue_src1=0x1234 one cycle after capture, or same cycle with RS_CDB_BYPASS_EN.
- Full/stall: 4 instructions all waiting on tag 6 → rs_full=1; a 5th id_en is not accepted. Broadcast tag 6 → all 4 issue in index order over 4 cycles, and rs_full drops.
- Backpressure: hold alu_ready=0 with issue_valid=1 for 3 cycles → issue_* stable and no entry freed; release → next entry issues.
- Flush: rs_flush with 3 entries plus a valid issue register → next cycle issue_valid=0, rs_full=0, and no later issue even if a matching CDB arrives.
- Same-cycle capture: allocation coincides with a CDB matching rs1 → entry captures cdb_value and issues without a further broadcast.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared defaults, tag-width helper and operand-source encoding for the ALU reservation station.
package alu_rs_pkg;

   localparam int RS_DEPTH_DEF     = 4;
   localparam int ROB_DEPTH_DEF    = 8;
   localparam int WORD_WIDTH_DEF   = 32;
   localparam int PC_WIDTH_DEF     = 32;
   localparam int ALU_OP_WIDTH_DEF = 4;

   // Where an operand's value comes from at allocation, highest priority first.
   typedef enum logic [1:0] {
      SRC_GPR  = 2'd0,
      SRC_CDB  = 2'd1,
      SRC_ROB  = 2'd2,
      SRC_WAIT = 2'd3
   } opnd_src_e;

   function automatic int tag_width(input int rob_depth);
      return (rob_depth > 1) ? $clog2(rob_depth) : 1;
   endfunction

   function automatic opnd_src_e opnd_src(input logic rat_valid, input logic cdb_hit,
                                          input logic rob_ready);
      if (!rat_valid)     return SRC_GPR;
      else if (cdb_hit)   return SRC_CDB;
      else if (rob_ready) return SRC_ROB;
      else                return SRC_WAIT;
   endfunction

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder: returns the first set request bit and a found flag.
module rs_pick #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] idx_o,
   output logic         found_o
);

   // Scanning downward lets the lowest set bit win the last assignment.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds renamed instructions until operands resolve, issues one per cycle.
// Optional RS_CDB_BYPASS_EN lets an entry waiting only on the current CDB tag issue that same cycle.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_DEPTH     = RS_DEPTH_DEF,
   parameter int ROB_DEPTH    = ROB_DEPTH_DEF,
   parameter int WORD_WIDTH   = WORD_WIDTH_DEF,
   parameter int PC_WIDTH     = PC_WIDTH_DEF,
   parameter int ALU_OP_WIDTH = ALU_OP_WIDTH_DEF,
   localparam int TAG_W       = tag_width(ROB_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_en,
   input  logic                    rs_flush,
   input  logic                    id_en,
   input  logic [PC_WIDTH-1:0]     id_pc,
   input  logic [ALU_OP_WIDTH-1:0] id_alu_op,
   input  logic                    id_use_imm,
   input  logic [WORD_WIDTH-1:0]   id_imm,
   input  logic [TAG_W-1:0]        id_alloc_rob,
   input  logic                    id_rs1_rat_valid,
   input  logic                    id_rs2_rat_valid,
   input  logic [TAG_W-1:0]        id_rs1_Paddr,
   input  logic [TAG_W-1:0]        id_rs2_Paddr,
   input  logic [WORD_WIDTH-1:0]   id_rs1_value_fromGPR,
   input  logic [WORD_WIDTH-1:0]   id_rs2_value_fromGPR,
   input  logic                    rob_rs1_ready,
   input  logic                    rob_rs2_ready,
   input  logic [WORD_WIDTH-1:0]   rob_rs1_value,
   input  logic [WORD_WIDTH-1:0]   rob_rs2_value,
   input  logic                    cdb_valid,
   input  logic [TAG_W-1:0]        cdb_rob,
   input  logic [WORD_WIDTH-1:0]   cdb_value,
   output logic                    rs_full,
   output logic                    issue_valid,
   input  logic                    alu_ready,
   output logic [ALU_OP_WIDTH-1:0] issue_alu_op,
   output logic [WORD_WIDTH-1:0]   issue_src1,
   output logic [WORD_WIDTH-1:0]   issue_src2,
   output logic [TAG_W-1:0]        issue_rob,
   output logic [PC_WIDTH-1:0]     issue_pc
);

   localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

   logic [RS_DEPTH-1:0]     valid_q, rdy1_q, rdy2_q;
   logic [ALU_OP_WIDTH-1:0] op_q   [RS_DEPTH];
   logic [PC_WIDTH-1:0]     pc_q   [RS_DEPTH];
   logic [TAG_W-1:0]        rob_q  [RS_DEPTH];
   logic [TAG_W-1:0]        tag1_q [RS_DEPTH];
   logic [TAG_W-1:0]        tag2_q [RS_DEPTH];
   logic [WORD_WIDTH-1:0]   val1_q [RS_DEPTH];
   logic [WORD_WIDTH-1:0]   val2_q [RS_DEPTH];

   logic                    issue_valid_q;
   logic [ALU_OP_WIDTH-1:0] issue_op_q;
   logic [WORD_WIDTH-1:0]   issue_src1_q, issue_src2_q;
   logic [TAG_W-1:0]        issue_rob_q;
   logic [PC_WIDTH-1:0]     issue_pc_q;

   logic [RS_DEPTH-1:0]     hit1, hit2, req_rdy;
   logic [IDX_W-1:0]        free_idx, sel_idx;
   logic                    free_found, sel_found;
   logic                    alloc, issue_load;
   opnd_src_e               src1_sel, src2_sel;
   logic                    new_rdy1, new_rdy2;
   logic [WORD_WIDTH-1:0]   new_val1, new_val2;
   logic [WORD_WIDTH-1:0]   sel_src1, sel_src2;

   assign rs_full = &valid_q;

   always_comb begin
      hit1    = '0;
      hit2    = '0;
      req_rdy = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         hit1[i] = cdb_valid && (tag1_q[i] == cdb_rob);
         hit2[i] = cdb_valid && (tag2_q[i] == cdb_rob);
`ifdef RS_CDB_BYPASS_EN
         req_rdy[i] = valid_q[i] && (rdy1_q[i] || hit1[i]) && (rdy2_q[i] || hit2[i]);
`else
         req_rdy[i] = valid_q[i] && rdy1_q[i] && rdy2_q[i];
`endif
      end
   end

   rs_pick #(.N(RS_DEPTH), .W(IDX_W)) u_free_pick (
      .req_i   (~valid_q),
      .idx_o   (free_idx),
      .found_o (free_found)
   );

   rs_pick #(.N(RS_DEPTH), .W(IDX_W)) u_sel_pick (
      .req_i   (req_rdy),
      .idx_o   (sel_idx),
      .found_o (sel_found)
   );

   assign alloc      = id_en && free_found;
   assign issue_load = (!issue_valid_q || alu_ready) && sel_found;

   // A not-yet-ready operand can only be selected when bypassing from the live CDB.
   assign sel_src1 = rdy1_q[sel_idx] ? val1_q[sel_idx] : cdb_value;
   assign sel_src2 = rdy2_q[sel_idx] ? val2_q[sel_idx] : cdb_value;

   always_comb begin
      src1_sel = opnd_src(id_rs1_rat_valid, cdb_valid && (cdb_rob == id_rs1_Paddr), rob_rs1_ready);
      src2_sel = opnd_src(id_rs2_rat_valid, cdb_valid && (cdb_rob == id_rs2_Paddr), rob_rs2_ready);
      new_rdy1 = (src1_sel != SRC_WAIT);
      new_rdy2 = (src2_sel != SRC_WAIT) || id_use_imm;
      case (src1_sel)
         SRC_GPR: new_val1 = id_rs1_value_fromGPR;
         SRC_CDB: new_val1 = cdb_value;
         SRC_ROB: new_val1 = rob_rs1_value;
         default: new_val1 = '0;
      endcase
      case (src2_sel)
         SRC_GPR: new_val2 = id_rs2_value_fromGPR;
         SRC_CDB: new_val2 = cdb_value;
         SRC_ROB: new_val2 = rob_rs2_value;
         default: new_val2 = '0;
      endcase
      if (id_use_imm) new_val2 = id_imm;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (cpu_en) begin
         if (rs_flush) begin
            valid_q <= '0;
         end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
               if (valid_q[i] && !rdy1_q[i] && hit1[i]) begin
                  rdy1_q[i] <= 1'b1;
                  val1_q[i] <= cdb_value;
               end
               if (valid_q[i] && !rdy2_q[i] && hit2[i]) begin
                  rdy2_q[i] <= 1'b1;
                  val2_q[i] <= cdb_value;
               end
               if (issue_load && (sel_idx == IDX_W'(i))) valid_q[i] <= 1'b0;
               // Free and selected indices never coincide: a free entry is not valid.
               if (alloc && (free_idx == IDX_W'(i))) begin
                  valid_q[i] <= 1'b1;
                  op_q[i]    <= id_alu_op;
                  pc_q[i]    <= id_pc;
                  rob_q[i]   <= id_alloc_rob;
                  tag1_q[i]  <= id_rs1_Paddr;
                  tag2_q[i]  <= id_rs2_Paddr;
                  rdy1_q[i]  <= new_rdy1;
                  rdy2_q[i]  <= new_rdy2;
                  val1_q[i]  <= new_val1;
                  val2_q[i]  <= new_val2;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_valid_q <= 1'b0;
         issue_op_q    <= '0;
         issue_src1_q  <= '0;
         issue_src2_q  <= '0;
         issue_rob_q   <= '0;
         issue_pc_q    <= '0;
      end else if (cpu_en) begin
         if (rs_flush) begin
            issue_valid_q <= 1'b0;
         end else if (issue_load) begin
            issue_valid_q <= 1'b1;
            issue_op_q    <= op_q[sel_idx];
            issue_src1_q  <= sel_src1;
            issue_src2_q  <= sel_src2;
            issue_rob_q   <= rob_q[sel_idx];
            issue_pc_q    <= pc_q[sel_idx];
         end else if (alu_ready) begin
            issue_valid_q <= 1'b0;
         end
      end
   end

   assign issue_valid  = issue_valid_q;
   assign issue_alu_op = issue_op_q;
   assign issue_src1   = issue_src1_q;
   assign issue_src2   = issue_src2_q;
   assign issue_rob    = issue_rob_q;
   assign issue_pc     = issue_pc_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against an entry-table model of the station.
module tb_alu_rs;

   localparam int D  = 4;
   localparam int TW = 3;
   localparam int WW = 32;
   localparam int PW = 32;
   localparam int OW = 4;
`ifdef RS_CDB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, cpu_en, rs_flush, id_en, id_use_imm, alu_ready;
   logic [PW-1:0] id_pc;
   logic [OW-1:0] id_alu_op;
   logic [WW-1:0] id_imm, gpr1, gpr2, robv1, robv2, cdb_value;
   logic [TW-1:0] id_alloc_rob, paddr1, paddr2, cdb_rob;
   logic          ratv1, ratv2, robr1, robr2, cdb_valid;
   logic          rs_full, issue_valid;
   logic [OW-1:0] issue_alu_op;
   logic [WW-1:0] issue_src1, issue_src2;
   logic [TW-1:0] issue_rob;
   logic [PW-1:0] issue_pc;

   alu_rs #(.RS_DEPTH(D), .ROB_DEPTH(8), .WORD_WIDTH(WW), .PC_WIDTH(PW), .ALU_OP_WIDTH(OW)) dut (
      .clk(clk), .rst(rst), .cpu_en(cpu_en), .rs_flush(rs_flush),
      .id_en(id_en), .id_pc(id_pc), .id_alu_op(id_alu_op), .id_use_imm(id_use_imm),
      .id_imm(id_imm), .id_alloc_rob(id_alloc_rob),
      .id_rs1_rat_valid(ratv1), .id_rs2_rat_valid(ratv2),
      .id_rs1_Paddr(paddr1), .id_rs2_Paddr(paddr2),
      .id_rs1_value_fromGPR(gpr1), .id_rs2_value_fromGPR(gpr2),
      .rob_rs1_ready(robr1), .rob_rs2_ready(robr2),
      .rob_rs1_value(robv1), .rob_rs2_value(robv2),
      .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
      .rs_full(rs_full), .issue_valid(issue_valid), .alu_ready(alu_ready),
      .issue_alu_op(issue_alu_op), .issue_src1(issue_src1), .issue_src2(issue_src2),
      .issue_rob(issue_rob), .issue_pc(issue_pc)
   );

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // Model: a table of station slots plus the issue register.
   bit            m_vld [D];
   bit            m_rdy1[D], m_rdy2[D];
   logic [OW-1:0] m_op  [D];
   logic [PW-1:0] m_pc  [D];
   logic [TW-1:0] m_rob [D], m_tag1[D], m_tag2[D];
   logic [WW-1:0] m_val1[D], m_val2[D];
   bit            m_iv;
   logic [OW-1:0] m_iop;
   logic [WW-1:0] m_is1, m_is2;
   logic [TW-1:0] m_irob;
   logic [PW-1:0] m_ipc;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_full();
      bit f = 1'b1;
      for (int i = 0; i < D; i++) f &= m_vld[i];
      return f;
   endfunction

   function automatic bit opnd_ok(input bit r, input logic [TW-1:0] t);
      return r || (BYP && cdb_valid && (cdb_rob == t));
   endfunction

   task automatic resolve(input bit ratv, input logic [TW-1:0] tag, input logic [WW-1:0] gpr,
                          input bit robr, input logic [WW-1:0] robv,
                          output bit r, output logic [WW-1:0] v);
      r = 1'b1;
      if (!ratv)                               v = gpr;
      else if (cdb_valid && cdb_rob == tag)    v = cdb_value;
      else if (robr)                           v = robv;
      else begin r = 1'b0; v = '0; end
   endtask

   // Advances the model by one clock edge using the inputs held across that edge.
   task automatic model_step();
      int  sel = -1;
      int  fr  = -1;
      bit  full;
      if (rst) begin
         for (int i = 0; i < D; i++) m_vld[i] = 1'b0;
         m_iv = 1'b0; m_iop = '0; m_is1 = '0; m_is2 = '0; m_irob = '0; m_ipc = '0;
         return;
      end
      if (!cpu_en) return;
      if (rs_flush) begin
         for (int i = 0; i < D; i++) m_vld[i] = 1'b0;
         m_iv = 1'b0;
         return;
      end
      full = model_full();
      for (int i = 0; i < D; i++)
         if (sel < 0 && m_vld[i] && opnd_ok(m_rdy1[i], m_tag1[i]) && opnd_ok(m_rdy2[i], m_tag2[i]))
            sel = i;
      for (int i = 0; i < D; i++) if (fr < 0 && !m_vld[i]) fr = i;
      if ((!m_iv || alu_ready) && sel >= 0) begin
         m_iv   = 1'b1;
         m_iop  = m_op[sel];
         m_is1  = m_rdy1[sel] ? m_val1[sel] : cdb_value;
         m_is2  = m_rdy2[sel] ? m_val2[sel] : cdb_value;
         m_irob = m_rob[sel];
         m_ipc  = m_pc[sel];
         m_vld[sel] = 1'b0;
      end else if (alu_ready) begin
         m_iv = 1'b0;
      end
      for (int i = 0; i < D; i++) begin
         if (m_vld[i] && !m_rdy1[i] && cdb_valid && cdb_rob == m_tag1[i]) begin
            m_rdy1[i] = 1'b1; m_val1[i] = cdb_value;
         end
         if (m_vld[i] && !m_rdy2[i] && cdb_valid && cdb_rob == m_tag2[i]) begin
            m_rdy2[i] = 1'b1; m_val2[i] = cdb_value;
         end
      end
      if (id_en && !full) begin
         m_vld[fr]  = 1'b1;
         m_op[fr]   = id_alu_op;
         m_pc[fr]   = id_pc;
         m_rob[fr]  = id_alloc_rob;
         m_tag1[fr] = paddr1;
         m_tag2[fr] = paddr2;
         resolve(ratv1, paddr1, gpr1, robr1, robv1, m_rdy1[fr], m_val1[fr]);
         if (id_use_imm) begin
            m_rdy2[fr] = 1'b1; m_val2[fr] = id_imm;
         end else begin
            resolve(ratv2, paddr2, gpr2, robr2, robv2, m_rdy2[fr], m_val2[fr]);
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("rs_full", rs_full, model_full());
         cmp("issue_valid", issue_valid, m_iv);
         cmp("issue_alu_op", issue_alu_op, m_iop);
         cmp("issue_src1", issue_src1, m_is1);
         cmp("issue_src2", issue_src2, m_is2);
         cmp("issue_rob", issue_rob, m_irob);
         cmp("issue_pc", issue_pc, m_ipc);
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 1'b0; cpu_en = 1'b1; rs_flush = 1'b0; id_en = 1'b0; alu_ready = 1'b1;
      id_pc = '0; id_alu_op = '0; id_use_imm = 1'b0; id_imm = '0; id_alloc_rob = '0;
      ratv1 = 1'b0; ratv2 = 1'b0; paddr1 = '0; paddr2 = '0; gpr1 = '0; gpr2 = '0;
      robr1 = 1'b0; robr2 = 1'b0; robv1 = '0; robv2 = '0;
      cdb_valid = 1'b0; cdb_rob = '0; cdb_value = '0;
   endtask

   task automatic alloc_instr(input logic [TW-1:0] rob, input bit pend1, input logic [TW-1:0] tag1,
                              input logic [WW-1:0] v1, input logic [WW-1:0] v2);
      id_en = 1'b1; id_alloc_rob = rob; id_pc = 32'h1000 + 32'(rob) * 4; id_alu_op = 4'h1;
      ratv1 = pend1; paddr1 = tag1; gpr1 = v1; robr1 = 1'b0;
      ratv2 = 1'b0; gpr2 = v2;
   endtask

   initial begin
      int got;
      idle();
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      idle();
      cmp("rst_issue_valid", issue_valid, 0);
      cmp("rst_rs_full", rs_full, 0);
      cmp("rst_issue_src1", issue_src1, 0);

      // Ready operands: issue visible two edges after presentation.
      alloc_instr(3'd3, 1'b0, 3'd0, 32'd5, 32'd7);
      tick(); idle();
      cmp("t1_not_yet", issue_valid, 0);
      tick();
      cmp("t1_valid", issue_valid, 1);
      cmp("t1_src1", issue_src1, 5);
      cmp("t1_src2", issue_src2, 7);
      cmp("t1_rob", issue_rob, 3);

      // CDB wakeup on rs1 tag 2, broadcast three cycles after allocation.
      alloc_instr(3'd4, 1'b1, 3'd2, 32'd0, 32'd9);
      tick(); idle();
      tick(); tick();
      cmp("t2_waiting", issue_valid, 0);
      cdb_valid = 1'b1; cdb_rob = 3'd2; cdb_value = 32'h1234;
      tick(); idle();
`ifdef RS_CDB_BYPASS_EN
      cmp("t2_bypass_valid", issue_valid, 1);
      cmp("t2_bypass_src1", issue_src1, 32'h1234);
`else
      cmp("t2_capture_gap", issue_valid, 0);
      tick();
      cmp("t2_valid", issue_valid, 1);
      cmp("t2_src1", issue_src1, 32'h1234);
`endif
      tick();

      // Fill all four slots waiting on tag 6; a fifth request must be refused.
      for (int k = 0; k < 4; k++) begin
         alloc_instr(TW'(k), 1'b1, 3'd6, 32'd0, 32'(k + 10));
         tick();
      end
      idle();
      cmp("t3_full", rs_full, 1);
      alloc_instr(3'd4, 1'b1, 3'd6, 32'd0, 32'd99);
      tick(); idle();
      cmp("t3_still_full", rs_full, 1);
      cdb_valid = 1'b1; cdb_rob = 3'd6; cdb_value = 32'h66;
      tick(); idle();
      got = 0;
      for (int c = 0; c < 8; c++) begin
         if (issue_valid) begin
            cmp("t3_order", issue_rob, got[TW-1:0]);
            cmp("t3_src1", issue_src1, 32'h66);
            cmp("t3_src2", issue_src2, 32'(got + 10));
            got++;
         end
         tick();
      end
      cmp("t3_count", got, 4);
      cmp("t3_drained", rs_full, 0);

      // Backpressure holds the issue register and the queued entry.
      alu_ready = 1'b0;
      alloc_instr(3'd5, 1'b0, 3'd0, 32'h55, 32'h1);
      tick();
      alloc_instr(3'd6, 1'b0, 3'd0, 32'h66, 32'h2);
      tick(); idle(); alu_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cmp("t4_hold_valid", issue_valid, 1);
         cmp("t4_hold_rob", issue_rob, 5);
         cmp("t4_hold_src1", issue_src1, 32'h55);
         tick();
      end
      alu_ready = 1'b1;
      tick();
      cmp("t4_next_rob", issue_rob, 6);
      cmp("t4_next_valid", issue_valid, 1);
      tick();

      // Flush kills three waiting entries and a stalled issue register.
      alu_ready = 1'b0;
      alloc_instr(3'd1, 1'b0, 3'd0, 32'h11, 32'h22);
      tick();
      for (int k = 2; k < 5; k++) begin
         alloc_instr(TW'(k), 1'b1, 3'd7, 32'd0, 32'd0);
         tick();
      end
      idle(); alu_ready = 1'b0;
      cmp("t5_pre_valid", issue_valid, 1);
      rs_flush = 1'b1;
      tick(); idle();
      cmp("t5_flush_valid", issue_valid, 0);
      cmp("t5_flush_full", rs_full, 0);
      cdb_valid = 1'b1; cdb_rob = 3'd7; cdb_value = 32'h77;
      tick(); idle();
      for (int c = 0; c < 3; c++) begin
         cmp("t5_no_issue", issue_valid, 0);
         tick();
      end

      // Allocation in the same cycle as the matching broadcast.
      alloc_instr(3'd7, 1'b1, 3'd5, 32'd0, 32'h3);
      cdb_valid = 1'b1; cdb_rob = 3'd5; cdb_value = 32'hABCD;
      tick(); idle();
      tick();
      cmp("t6_valid", issue_valid, 1);
      cmp("t6_src1", issue_src1, 32'hABCD);

      // Randomized traffic checked cycle by cycle against the model.
      for (int n = 0; n < 3000; n++) begin
         rst          = ($urandom_range(0, 299) == 0);
         cpu_en       = ($urandom_range(0, 9) != 0);
         rs_flush     = ($urandom_range(0, 59) == 0);
         id_en        = $urandom_range(0, 1);
         id_pc        = $urandom;
         id_alu_op    = OW'($urandom);
         id_use_imm   = ($urandom_range(0, 3) == 0);
         id_imm       = $urandom;
         id_alloc_rob = TW'($urandom);
         ratv1        = $urandom_range(0, 1);
         ratv2        = $urandom_range(0, 1);
         paddr1       = TW'($urandom);
         paddr2       = TW'($urandom);
         gpr1         = $urandom;
         gpr2         = $urandom;
         robr1        = ($urandom_range(0, 3) == 0);
         robr2        = ($urandom_range(0, 3) == 0);
         robv1        = $urandom;
         robv2        = $urandom;
         cdb_valid    = $urandom_range(0, 1);
         cdb_rob      = TW'($urandom);
         cdb_value    = $urandom;
         alu_ready    = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
